link_tx_sequencer: RTL
======================

// Module: link_tx_sequencer
// PURPOSE
// - Per-link transmit sequencer. Produces the 8-bit/160 MHz word stream and drive-enable for one OSERDES/IOBUFDS lane.
// - Sends a turn-on guard preamble, then a training pattern so the far-end receiver can run its delay/bit alignment.
// - Then forwards user AXI-stream data, filling gaps with an idle word.
// - tx_tvalid=0 tristates the lane; tx_tvalid=1 drives tx_tdata.
// PARAMETERS
// - TRAIN_WORD  8'hF0   pattern sent during TRAIN
// - IDLE_WORD   8'hAC   filler in GUARD and STREAM when no user data
// - TURN_GUARD  4       GUARD length in cycles; 0 = skip GUARD
// - CNT_W       16      width of train_len / training counter
// PORTS
// - clk160      in   1      link word clock
// - rstb        in   1      reset, synchronous, active-low
// - enable      in   1      1 = drive lane, 0 = tristate (OFF)
// - train_req   in   1      single-cycle request to start training
// - train_len   in   CNT_W  training length in words, sampled with train_req
// - cnt_clear   in   1      clears words_sent
// - s_tdata     in   8      user data
// - s_tvalid    in   1      user data valid
// - s_tready    out  1      combinational: (state==STREAM) && enable && !train_req
// - tx_tdata    out  8      registered word to OSERDES D
// - tx_tvalid   out  1      registered drive-enable (OSERDES T = ~tx_tvalid)
// - train_done  out  1      one-cycle pulse when TRAIN completes
// - state_out   out  3      OFF=0 GUARD=1 STREAM=2 TRAIN=3 PRBS=4
// - words_sent  out  32     accepted user words, saturating
// BEHAVIOUR
// - Reset (rstb=0 at clk edge):
//   - state OFF; tx_tdata=0, tx_tvalid=0, train_done=0, words_sent=0.
//   - s_tready=0 because state is OFF.
// - Latency: s_tdata reaches tx_tdata 1 cycle after the s_tvalid&&s_tready edge. No user word is lost or duplicated.
// - enable=0 in any state: next state is OFF; tx_tvalid=0 and tx_tdata=0 on the next cycle.
//   - An in-progress TRAIN is abandoned with no train_done pulse.
// - OFF & enable=1: go to GUARD, driving IDLE_WORD with tvalid=1 for exactly TURN_GUARD cycles, then STREAM.
//   - If TURN_GUARD=0, go directly to STREAM.
// - STREAM: each cycle output s_tdata if accepted, else IDLE_WORD; tvalid=1.
// - STREAM & train_req:
//   - train_req wins over s_tvalid that cycle (s_tready=0).
//   - train_len>0: go to TRAIN and load the counter.
//   - train_len==0: stay in STREAM and pulse train_done on the next cycle.
// - TRAIN: output TRAIN_WORD for exactly train_len cycles, then return to STREAM.
//   - train_done pulses in the first STREAM cycle.
//   - train_req is ignored in TRAIN.
// - train_req in OFF or GUARD is ignored, not queued.
// - words_sent increments on each s_tvalid&&s_tready and saturates at 32'hFFFF_FFFF.
//   - cnt_clear has priority over a simultaneous increment (result 0).
// CONFIGURATION
// - Macro LINK_TX_PRBS_EN.
// - Defined:
//   - Adds input prbs_mode (1 bit) and state PRBS.
//   - STREAM & prbs_mode & !train_req: go to PRBS.
//   - PRBS outputs 8 bits/cycle of PRBS7 (x^7+x^6+1, seed 7'h7F, MSB first); s_tready=0; train_req is ignored.
//   - prbs_mode=0: return to STREAM.
//   - The LFSR reseeds on every entry to PRBS.
// - Undefined: no prbs_mode port; PRBS is never entered; encoding 4 is unused.
// STRUCTURE
// - Package link_tx_pkg:
//   - state enum tx_state_t (3-bit, encodings above).
//   - default TRAIN_WORD and IDLE_WORD constants.
//   - PRBS7 seed/tap constants.
// - Sub-module link_tx_prbs7 (8-bit/cycle parallel PRBS7, with load and advance inputs).
//   - Instantiated only under LINK_TX_PRBS_EN.
// TESTING
// - Reset: rstb=0 for 2 cycles, enable=1 -> tx_tvalid=0, tx_tdata=00, s_tready=0, state_out=0, words_sent=0.
// - Turn-on: enable rises with TURN_GUARD=4 -> 4 cycles of tx_tdata=AC with tvalid=1, then state_out=2 and s_tready=1.
// - Stream: send 01,02, one idle cycle, 03 -> tx_tdata 01,02,AC,03 one cycle later; words_sent=3.
// - Train: train_req, train_len=5, with s_tvalid=1 (s_tdata=55) held -> s_tready=0, then F0 x5, train_done pulse, then 55.
//   - train_len=0 -> no F0 output; train_done next cycle.
// - Abort: enable=0 during the 3rd TRAIN word -> next cycle tx_tvalid=0, state_out=0, train_done stays 0.
// - Counter/PRBS:
//   - cnt_clear together with an accept -> words_sent=0.
//   - Force words_sent=FFFFFFFF, then accept -> stays FFFFFFFF.
//   - With LINK_TX_PRBS_EN: 127 bytes match the bench PRBS7 model, and byte 128 equals byte 1.

Source files
------------

// File: rtl/link_tx_pkg.sv
// link_tx_pkg: state encoding, default words and PRBS7 constants for the link transmit sequencer.
package link_tx_pkg;
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_GUARD  = 3'd1,
        ST_STREAM = 3'd2,
        ST_TRAIN  = 3'd3,
        ST_PRBS   = 3'd4
    } tx_state_t;
    localparam logic [7:0] TRAIN_WORD_DEF = 8'hF0;
    localparam logic [7:0] IDLE_WORD_DEF  = 8'hAC;
    localparam logic [6:0] PRBS7_SEED     = 7'h7F;
    localparam logic [6:0] PRBS7_TAPS     = 7'h60;
    // Eight serial PRBS7 steps; returns {byte (first bit in MSB), next lfsr}.
    function automatic logic [14:0] prbs7_step(input logic [6:0] s);
        logic [6:0] l;
        logic [7:0] b;
        logic       fb;
        l = s;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            fb       = ^(l & PRBS7_TAPS);
            b[7 - i] = fb;
            l        = {l[5:0], fb};
        end
        return {b, l};
    endfunction
endpackage

// File: rtl/link_tx_prbs7.sv
// link_tx_prbs7: 8-bit/cycle PRBS7 (x^7+x^6+1) generator, reseeded by load, stepped by advance.
module link_tx_prbs7
    import link_tx_pkg::*;
(
    input  logic       clk160,
    input  logic       rstb,
    input  logic       load,
    input  logic       advance,
    output logic [7:0] byte_out
);
    logic [6:0]  lfsr;
    logic [14:0] step;

    assign step     = prbs7_step(lfsr);
    assign byte_out = step[14:7];

    always_ff @(posedge clk160) begin
        if (!rstb || load) lfsr <= PRBS7_SEED;
        else if (advance)  lfsr <= step[6:0];
    end
endmodule

// File: rtl/link_tx_sequencer.sv
// link_tx_sequencer: per-lane transmit sequencer (guard, training, user stream, idle fill).
// Define LINK_TX_PRBS_EN to add the prbs_mode input and the PRBS7 test state.
module link_tx_sequencer
    import link_tx_pkg::*;
#(
    parameter logic [7:0] TRAIN_WORD = TRAIN_WORD_DEF,
    parameter logic [7:0] IDLE_WORD  = IDLE_WORD_DEF,
    parameter int         TURN_GUARD = 4,
    parameter int         CNT_W      = 16
) (
    input  logic             clk160,
    input  logic             rstb,
    input  logic             enable,
    input  logic             train_req,
    input  logic [CNT_W-1:0] train_len,
    input  logic             cnt_clear,
    input  logic [7:0]       s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [7:0]       tx_tdata,
    output logic             tx_tvalid,
    output logic             train_done,
    output logic [2:0]       state_out,
    output logic [31:0]      words_sent
`ifdef LINK_TX_PRBS_EN
    ,
    input  logic             prbs_mode
`endif
);
    tx_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [7:0]       tdata_nx, prbs_byte;
    logic             tvalid_nx, done_nx, accept, prbs_go;

`ifdef LINK_TX_PRBS_EN
    assign prbs_go = prbs_mode;
    link_tx_prbs7 u_prbs (
        .clk160   (clk160),
        .rstb     (rstb),
        .load     (state != ST_PRBS && state_nx == ST_PRBS),
        .advance  (state == ST_PRBS),
        .byte_out (prbs_byte)
    );
`else
    assign prbs_go   = 1'b0;
    assign prbs_byte = 8'h00;
`endif

    assign state_out = state;

    always_ff @(posedge clk160) begin
        if (!rstb) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!enable) state_nx = ST_OFF;
        else begin
            case (state)
                ST_OFF:    state_nx = (TURN_GUARD == 0) ? ST_STREAM : ST_GUARD;
                ST_GUARD:  state_nx = (cnt == '0) ? ST_STREAM : ST_GUARD;
                ST_STREAM: state_nx = train_req ? ((train_len != '0) ? ST_TRAIN : ST_STREAM)
                                                : (prbs_go ? ST_PRBS : ST_STREAM);
                ST_TRAIN:  state_nx = (cnt == '0) ? ST_STREAM : ST_TRAIN;
                ST_PRBS:   state_nx = prbs_go ? ST_PRBS : ST_STREAM;
                default:   state_nx = ST_OFF;
            endcase
        end
    end

    // One down-counter serves both GUARD and TRAIN; it is loaded on entry and exits at zero.
    always_comb begin
        s_tready  = (state == ST_STREAM) && enable && !train_req;
        accept    = s_tvalid && s_tready;
        cnt_nx    = (state_nx == ST_GUARD && state != ST_GUARD) ? CNT_W'(TURN_GUARD - 1) :
                    (state_nx == ST_TRAIN && state != ST_TRAIN) ? train_len - 1'b1 : cnt - 1'b1;
        tvalid_nx = enable && (state != ST_OFF);
        tdata_nx  = !tvalid_nx           ? 8'h00 :
                    (state == ST_GUARD)  ? IDLE_WORD :
                    (state == ST_TRAIN)  ? TRAIN_WORD :
                    (state == ST_PRBS)   ? prbs_byte :
                    accept               ? s_tdata : IDLE_WORD;
        done_nx   = enable && ((state == ST_STREAM && train_req && train_len == '0) ||
                               (state == ST_TRAIN && cnt == '0));
    end

    always_ff @(posedge clk160) begin
        if (!rstb) begin
            tx_tdata   <= 8'h00;
            tx_tvalid  <= 1'b0;
            train_done <= 1'b0;
            words_sent <= '0;
        end else begin
            tx_tdata   <= tdata_nx;
            tx_tvalid  <= tvalid_nx;
            train_done <= done_nx;
            words_sent <= cnt_clear ? '0 : (accept && !(&words_sent)) ? words_sent + 1'b1 : words_sent;
        end
    end
endmodule
